// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - CP0 interrupt front end: sync, pending, mask, take/service handshake (optional INTC_EDGE_DETECT_EN)
module interrupt_controller #(
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  irq_i,
    input  logic        ie_i,
    input  logic [3:0]  im_i,
    input  logic        int_ack,
    input  logic        eret,
    output logic        int_req,
    output logic        EPCWrite,
    output logic        CauseWrite,
    output logic [1:0]  IntCause,
    output logic [31:0] vector_o,
    output logic        in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  pending;
    logic [3:0]  masked;
    logic [1:0]  cause;
    logic [1:0]  cause_sel;
    logic        accept;

    // Bit 0 (timer) has the highest priority.
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Two-flop synchroniser for the asynchronous peripheral lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 4'b0;
            s2 <= 4'b0;
        end else begin
            s1 <= irq_i;
            s2 <= s1;
        end
    end

`ifdef INTC_EDGE_DETECT_EN
    logic [3:0] s3;
    logic [3:0] pend_set;
    logic [3:0] pend_clr;

    assign pend_set = s2 & ~s3;
    assign pend_clr = (state == TAKE) ? (4'b0001 << cause) : 4'b0000;

    // Rising-edge latch; a set in the same cycle as the TAKE clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3      <= 4'b0;
            pending <= 4'b0;
        end else begin
            s3      <= s2;
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end
`else
    // Level mode: the peripheral holds its line until software clears it.
    assign pending = s2;
`endif

    assign masked    = pending & im_i;
    assign cause_sel = lowest_set(masked);
    assign accept    = (state == IDLE) && int_ack && ie_i && (|masked);

    // Cause is captured at acceptance and drives the vector until the next take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause <= 2'd0;
        end else if (accept) begin
            cause <= cause_sel;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: ack only counts in IDLE with a live request, eret only in SERVICE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = TAKE;
            TAKE:    state_next = SERVICE;
            SERVICE: if (eret) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: request is live from mask/enable; strobes last exactly the TAKE cycle.
    always_comb begin
        int_req    = 1'b0;
        EPCWrite   = 1'b0;
        CauseWrite = 1'b0;
        IntCause   = 2'd0;
        in_service = 1'b0;
        case (state)
            IDLE: begin
                int_req = ie_i & (|masked);
            end
            TAKE: begin
                EPCWrite   = 1'b1;
                CauseWrite = 1'b1;
                IntCause   = cause;
            end
            SERVICE: begin
                in_service = 1'b1;
            end
            default: begin
                int_req = 1'b0;
            end
        endcase
    end

    assign vector_o = VECTOR_BASE + {27'd0, cause, 3'b000};

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Upstream interrupt front end for the MIPS coprocessor (CP0). Synchronises four peripheral interrupt lines, keeps pending state and applies masking. Handshakes with the multicycle control unit at instruction boundaries. On acceptance it produces the one-cycle EPCWrite/CauseWrite/IntCause strobe that CP0 consumes, plus the handler vector, and then blocks nesting until `eret`.

## Interface
- `VECTOR_BASE`, default 32'h0000_0004: handler base address; vector = base + cause×8.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `irq_i` in 4: raw peripheral requests (bit0 = timer, bit1 = UART, bit2 = PS/2, bit3 = switches); asynchronous to `clk`.
- `ie_i` in 1: global interrupt enable (Status.IE from CP0 register 12).
- `im_i` in 4: per-source mask, 1 = enabled.
- `int_ack` in 1: control unit accepts the request this cycle. Only valid at an instruction boundary.
- `eret` in 1: control unit is executing `eret` (one-cycle pulse).
- `int_req` out 1: interrupt ready to be taken.
- `EPCWrite` out 1: to CP0, latch PC into EPC.
- `CauseWrite` out 1: to CP0, latch IntCause into Cause.
- `IntCause` out 2: index of the source being taken.
- `vector_o` out 32: handler address for the PC mux.
- `in_service` out 1: handler running, further requests blocked.

## Operation
- Every `irq_i` bit passes through a 2-flop synchroniser (`s1`, `s2`).
- `pending[i]` depends on the configuration; see Configuration.
- `masked = pending & im_i`.
- States:
  - IDLE: `int_req = ie_i & |masked`.
    - `int_ack & int_req` → latch cause = lowest set index of `masked` (bit0 highest priority); go to TAKE.
    - `int_ack` without `int_req` is ignored.
  - TAKE: lasts exactly 1 cycle.
    - `EPCWrite = CauseWrite = 1`, `IntCause = cause`, `int_req = 0`.
    - Go to SERVICE.
  - SERVICE: `int_req = 0`, `in_service = 1`.
    - `eret` → IDLE on the next edge.
- `eret` in IDLE or TAKE is ignored.
- `int_ack` in TAKE or SERVICE is ignored.
- `vector_o = VECTOR_BASE + {cause, 3'b000}` from the registered cause. It holds its value until the next TAKE.
- Arithmetic is 32-bit unsigned; wrap-around is ignored.
- Reset mid-operation (any state) → IDLE with all state cleared immediately. Any TAKE strobe in progress is aborted.

## Timing
- Reset values:
  - `int_req`, `EPCWrite`, `CauseWrite`, `in_service` = 0.
  - `IntCause` = 0.
  - `vector_o = VECTOR_BASE`.
  - Synchronisers, pending, cause and state = 0 / IDLE.
- `int_req` is combinational from registered state and from `ie_i` and `im_i`.
  - A mask or enable change affects `int_req` in the same cycle.
- Level mode: `irq_i` sampled high at edge k → `int_req` high after edge k+1.
- Edge mode: sampled high at edge k → `int_req` high after edge k+2.
- `int_ack` at edge n → EPCWrite/CauseWrite high for the cycle after edge n, then low after edge n+1.
- `eret` at edge m → `in_service` low after edge m. `int_req` may re-assert in that same cycle.
- Minimum spacing between two accepted interrupts is 3 cycles.

## Configuration
- `INTC_EDGE_DETECT_EN` defined (edge mode):
  - An extra flop `s3` holds the previous value of `s2`.
  - `pending[i]` is set on `s2 & ~s3` and cleared in TAKE for the taken source.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - Non-taken pending bits are retained.
- Undefined (level mode):
  - `pending = s2`, with no latching.
  - The peripheral must hold its request until software clears it.
  - TAKE does not modify `pending`.

## Test plan
- Reset while in SERVICE (`rst` pulse) → outputs at reset values, `vector_o = 32'h0000_0004`.
- `ie_i = 1`, `im_i = 4'b1111`, `irq_i = 4'b0110`, then `int_ack` → one-cycle EPCWrite = CauseWrite = 1, `IntCause = 2'd1`, `vector_o = 32'h0000_000C`.
- `im_i = 4'b0000` with `irq_i = 4'b0001` → `int_req` stays 0.
  - Set `im_i = 4'b0001` → `int_req = 1` in the same cycle.
- In SERVICE, `irq_i[0]` rises → `int_req = 0` until `eret`.
  - After `eret`: `int_req = 1` and `IntCause = 0` on the next ack.
- Edge mode: `irq_i[3]` pulses for 1 cycle and `irq_i[2]` is held high. Ack twice with `eret` between.
  - Causes taken: 2 then 3.
  - `pending[3]` is held until taken.
  - `pending[2]` is not re-set while the line stays high.
- `int_ack` asserted in IDLE with no pending request, and `eret` in IDLE → state unchanged, no strobes.
